// File: rtl/bram_sdp_be.sv
// Simple-dual-port block RAM with per-byte write enables, a 1- or 2-cycle
// read pipeline with a valid strobe, selectable read-during-write policy,
// and a clear sequencer that fills every word with CLR_VAL after reset or
// on request. Single clock, synchronous active-high reset.
module bram_sdp_be #(
    parameter int                  DATA_W   = 32,
    parameter int                  ADDR_W   = 3,
    parameter int                  BYTE_W   = 8,
    parameter int                  RD_LAT   = 1,
    parameter int                  RDW_MODE = 0,
    parameter logic [DATA_W-1:0]   CLR_VAL  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_start,
    output logic                       busy,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/BYTE_W-1:0]   wr_be,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid
);

    localparam int                NBE   = DATA_W / BYTE_W;
    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_fire;
    logic                rd_fire;
    logic                clr_fire;
    logic [DATA_W-1:0]   rd_word_p0;

    // User accesses are only accepted in IDLE and never while rst is high;
    // a clear request in the same cycle takes priority over a write.
    assign wr_fire  = (state == IDLE) && !rst && we && !clr_start;
    assign rd_fire  = (state == IDLE) && !rst && rd_en;
    assign clr_fire = (state == CLEAR) && !rst;

    // Control FSM: clear sequencer walking clr_cnt across the whole array.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Array write port: clear word has priority, otherwise byte-masked write.
    always_ff @(posedge clk) begin
        if (clr_fire) begin
            mem[clr_cnt] <= CLR_VAL;
        end else if (wr_fire) begin
            for (int i = 0; i < NBE; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Array read word; in write-first mode a same-address write is merged
    // lane by lane so the read sees the post-write contents.
    always_comb begin
        rd_word_p0 = mem[rd_addr];
        if ((RDW_MODE == 1) && wr_fire && (wr_addr == rd_addr)) begin
            for (int i = 0; i < NBE; i++) begin
                if (wr_be[i]) begin
                    rd_word_p0[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] rd_word_p1;
            logic              vld_p1;

            // Stage 1: array register captures the word of an accepted read.
            always_ff @(posedge clk) begin
                if (rd_fire) begin
                    rd_word_p1 <= rd_word_p0;
                end
            end

            // Stage 1 valid; flushed by rst but not by a clear request.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p1 <= 1'b0;
                end else begin
                    vld_p1 <= rd_fire;
                end
            end

            // Stage 2: output register, holds its value between reads.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= vld_p1;
                    if (vld_p1) begin
                        rd_data <= rd_word_p1;
                    end
                end
            end
        end else begin : g_lat1
            // Single stage: output register loaded directly from the array.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_fire;
                    if (rd_fire) begin
                        rd_data <= rd_word_p0;
                    end
                end
            end
        end
    endgenerate

endmodule
